l1_dcache_wb: RTL
=================

Name: l1_dcache_wb

Overview:
- Direct-mapped, write-back, write-allocate L1 data cache for the LC-3b pipeline.
- Sits directly downstream of the MEM stage and consumes its control-word outputs: mem_read, mem_write, the 2-bit byte write mask, the address and the store data.
- Returns 16-bit load data and a response strobe.
- Fills and evicts 128-bit lines over a single-outstanding-request physical-memory port.

Parameters:
- IDX_W, 3: set-index width; number of sets = 2^IDX_W = 8.
- TAG_W, 9: tag width.
- Fixed relation: TAG_W + IDX_W + 4 = 16 (4-bit line offset, 128-bit line).

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset.
- mem_address  in  16  byte address from MEM stage; bit 0 is ignored for word access.
- mem_read  in  1  load request; held stable until mem_resp.
- mem_write  in  1  store request; held stable until mem_resp.
- mem_wmask  in  2  byte enables for stores; bit0 selects [7:0], bit1 selects [15:8].
- mem_wdata  in  16  store data.
- mem_rdata  out  16  load data; valid when mem_resp=1.
- mem_resp  out  1  request complete (single-cycle pulse per request).
- pmem_address  out  16  line address; low 4 bits are always 0.
- pmem_read  out  1  line fill request; held until pmem_resp.
- pmem_write  out  1  line writeback request; held until pmem_resp.
- pmem_wdata  out  128  eviction data.
- pmem_rdata  in  128  fill data; valid with pmem_resp.
- pmem_resp  in  1  physical-memory transfer complete.

Behaviour:
- Address split:
  - tag = addr[15:7]
  - index = addr[6:4]
  - word = addr[3:1], which selects bits [16*word +: 16] of the line.
- Per-set storage: valid bit, dirty bit, tag, 128-bit line.
- Reset: all valid and dirty bits are cleared; tag and data arrays are not reset.
  - FSM goes to IDLE.
  - Reset values of outputs: mem_resp=0, pmem_read=0, pmem_write=0, pmem_address=0, pmem_wdata=don't-care, mem_rdata=don't-care.
- Request validity: mem_read and mem_write both high is illegal. The cache treats it as a write.
- hit = valid[index] && tag_array[index]==tag.
- FSM states:
  - IDLE, no request: nothing happens; no pmem activity.
  - IDLE, request and hit: mem_resp=1 combinationally in that same cycle.
    - Load: mem_rdata = selected word.
    - Store: at the clock edge, each byte lane with a set wmask bit is written. dirty[index] is set if mem_wmask != 0. mem_wmask=00 completes with no change.
    - Stay in IDLE.
  - IDLE, miss with valid && dirty: go to WRITEBACK.
  - IDLE, miss otherwise: go to ALLOCATE.
  - WRITEBACK:
    - pmem_write=1, pmem_address={tag_array[index], index, 4'b0}, pmem_wdata=line[index].
    - On pmem_resp: clear dirty[index] and go to ALLOCATE.
  - ALLOCATE:
    - pmem_read=1, pmem_address={tag, index, 4'b0}.
    - On pmem_resp: line[index]=pmem_rdata, tag_array[index]=tag, valid=1, dirty=0; go to IDLE.
    - The request then hits on the next cycle.
- Latency:
  - Hit: 0 extra cycles.
  - Clean miss: Tfill + 2 cycles.
  - Dirty miss: Twb + Tfill + 2 cycles.
- pmem_read and pmem_write are never high together.
- Exactly one mem_resp is produced per request.
- Reset mid-miss:
  - The next cycle is IDLE with pmem_read and pmem_write deasserted.
  - A pmem_resp arriving later is ignored.
  - No array update from the aborted transfer.
- The MEM stage must not change the address while mem_resp=0. Behaviour under an unstable request is undefined.

Test Plan:
1. Reset, then mem_read at 0x0042 -> clean miss. pmem_read=1 at 0x0040. Return pmem_rdata with word1=0xBEEF. Next cycle: mem_resp=1, mem_rdata=0xBEEF.
2. After (1), mem_write 0x0042, wmask=01, wdata=0x1234 -> same-cycle mem_resp. A following read of 0x0042 returns 0xBE34 with 0 pmem activity.
3. After (2), read 0x00C2 (same index 4, new tag) -> pmem_write=1 at 0x0040 with pmem_wdata word1=0xBE34, then pmem_read at 0x00C0, then mem_resp.
4. Write with wmask=00 to a clean hit line, then evict that line -> no WRITEBACK state is entered (dirty was not set).
5. Assert reset during ALLOCATE before pmem_resp -> pmem_read=0 next cycle. A re-read of the same address misses again.
6. Read 0x0010 and 0x0020 (indices 1 and 2): both miss. Re-read both -> both hit, showing sets are independent.

Source files
------------

// File: rtl/l1_dcache_wb.sv
// Direct-mapped, write-back, write-allocate L1 data cache.
// It has 2^IDX_W sets of 128-bit lines and one outstanding line transfer on the pmem port.
module l1_dcache_wb #(
    parameter int IDX_W = 3,
    parameter int TAG_W = 9
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [15:0]  mem_address,
    input  logic         mem_read,
    input  logic         mem_write,
    input  logic [1:0]   mem_wmask,
    input  logic [15:0]  mem_wdata,
    output logic [15:0]  mem_rdata,
    output logic         mem_resp,
    output logic [15:0]  pmem_address,
    output logic         pmem_read,
    output logic         pmem_write,
    output logic [127:0] pmem_wdata,
    input  logic [127:0] pmem_rdata,
    input  logic         pmem_resp
);
    localparam int SETS = 1 << IDX_W;

    typedef enum logic [1:0] {IDLE, WRITEBACK, ALLOCATE} state_e;

    state_e             state_q, state_d;
    logic [SETS-1:0]    valid_q, valid_d;
    logic [SETS-1:0]    dirty_q, dirty_d;
    logic [TAG_W-1:0]   tag_q  [SETS];
    logic [127:0]       line_q [SETS];

    logic [TAG_W-1:0]   tag;
    logic [IDX_W-1:0]   idx;
    logic [2:0]         word;
    logic               req, hit, fill;

    assign tag  = mem_address[15 -: TAG_W];
    assign idx  = mem_address[4 +: IDX_W];
    assign word = mem_address[3:1];
    assign req  = mem_read | mem_write;
    assign hit  = valid_q[idx] && (tag_q[idx] == tag);
    assign fill = (state_q == ALLOCATE) && pmem_resp;

    assign mem_rdata  = line_q[idx][{word, 4'b0000} +: 16];
    assign pmem_wdata = line_q[idx];

    always_comb begin
        state_d      = state_q;
        valid_d      = valid_q;
        dirty_d      = dirty_q;
        mem_resp     = 1'b0;
        pmem_read    = 1'b0;
        pmem_write   = 1'b0;
        pmem_address = 16'h0000;
        case (state_q)
            IDLE: begin
                if (req) begin
                    if (hit) begin
                        mem_resp = 1'b1;
                        // Having both read and write high counts as a write.
                        if (mem_write && (mem_wmask != 2'b00))
                            dirty_d[idx] = 1'b1;
                    end else if (valid_q[idx] && dirty_q[idx]) begin
                        state_d = WRITEBACK;
                    end else begin
                        state_d = ALLOCATE;
                    end
                end
            end
            WRITEBACK: begin
                pmem_write   = 1'b1;
                pmem_address = {tag_q[idx], idx, 4'b0000};
                if (pmem_resp) begin
                    dirty_d[idx] = 1'b0;
                    state_d      = ALLOCATE;
                end
            end
            ALLOCATE: begin
                pmem_read    = 1'b1;
                pmem_address = {tag, idx, 4'b0000};
                if (pmem_resp) begin
                    valid_d[idx] = 1'b1;
                    dirty_d[idx] = 1'b0;
                    state_d      = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            valid_q <= '0;
            dirty_q <= '0;
        end else begin
            state_q <= state_d;
            valid_q <= valid_d;
            dirty_q <= dirty_d;
        end
    end

    // The tag and data arrays are not reset. The reset guard stops an aborted fill from landing.
    always_ff @(posedge clk) begin
        if (!reset) begin
            if (fill) begin
                line_q[idx] <= pmem_rdata;
                tag_q[idx]  <= tag;
            end else if (mem_resp && mem_write) begin
                for (int b = 0; b < 2; b++)
                    if (mem_wmask[b])
                        line_q[idx][{word, 4'b0000} + 7'(b * 8) +: 8] <= mem_wdata[b*8 +: 8];
            end
        end
    end
endmodule
